// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the instruction memory handshake and buffers
// fetched words in a 2-entry queue for decode. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ACKI_n,
    input  logic [31:0] IDT,
    output logic [31:0] IAD,
    output logic        IREQ,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, STALL, HALT} state_t;
`else
    typedef enum logic [0:0] {FETCH, STALL} state_t;
`endif

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic        ireq_q;
    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] pc_q   [2];
    logic [31:0] inst_q [2];
    logic        accept;
    logic        pop;
    logic        redirect_misaligned;
    logic [31:0] redirect_target;
    logic        misalign_q;

    assign accept          = ireq_q & ~ACKI_n;
    assign pop             = id_valid & id_ready;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign misalign            = misalign_q;
`else
    // Low target bits are dropped, so a misaligned redirect simply rounds down.
    logic unused_redirect_low;
    assign redirect_misaligned = 1'b0;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Control FSM; IREQ is registered from the next state so a full queue
    // drops the request in the very next cycle. Redirect outranks everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            ireq_q     <= 1'b0;
            fetch_pc   <= RESET_PC_ALIGNED;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                if (redirect_misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state      <= HALT;
                    misalign_q <= 1'b1;
`endif
                    ireq_q <= 1'b0;
                end else begin
                    fetch_pc <= redirect_target;
                    state    <= FETCH;
                    ireq_q   <= 1'b1;
                end
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count_next;
                case (state)
                    FETCH, STALL: begin
                        if (count_next == 2'd2) begin
                            state  <= STALL;
                            ireq_q <= 1'b0;
                        end else begin
                            state  <= FETCH;
                            ireq_q <= 1'b1;
                        end
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    HALT: begin
                        state  <= HALT;
                        ireq_q <= 1'b0;
                    end
                    default: begin
                        state  <= FETCH;
                        ireq_q <= 1'b0;
                    end
`endif
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect && accept) begin
            pc_q[wr_ptr]   <= fetch_pc;
            inst_q[wr_ptr] <= IDT;
        end
    end

    // Head fields read as zero when the queue is empty so reset leaves them clean.
    assign IAD      = fetch_pc;
    assign IREQ     = ireq_q;
    assign id_valid = (count != 2'd0);
    assign id_inst  = id_valid ? inst_q[rd_ptr] : 32'd0;
    assign id_pc    = id_valid ? pc_q[rd_ptr] : 32'd0;
    assign id_pc4   = id_valid ? (pc_q[rd_ptr] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ACKI_n;
    logic [31:0] IDT;
    logic [31:0] IAD;
    logic        IREQ;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ACKI_n      (ACKI_n),
        .IDT         (IDT),
        .IAD         (IAD),
        .IREQ        (IREQ),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack_n, input logic [31:0] idt, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        ACKI_n      = ack_n;
        IDT         = idt;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        checkOutput("rst_ireq",  {31'd0, IREQ}, 32'd0);
        checkOutput("rst_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("rst_iad",   IAD, 32'd0);
        checkOutput("rst_inst",  id_inst, 32'd0);
        checkOutput("rst_pc",    id_pc, 32'd0);
        checkOutput("rst_pc4",   id_pc4, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
`endif

        rst = 1'b0;
        tick();
        checkOutput("first_ireq", {31'd0, IREQ}, 32'd1);
        checkOutput("first_iad",  IAD, 32'd0);

        // Streaming: one instruction per cycle, decode always ready.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("stream_valid", {31'd0, id_valid}, 32'd1);
            checkOutput("stream_pc",    id_pc, 32'(4 * k));
            checkOutput("stream_inst",  id_inst, 32'(k));
            checkOutput("stream_iad",   IAD, 32'(4 * (k + 1)));
            IDT = 32'(k + 1);
        end
        applyStimulus(1'b1, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("drain_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("drain_iad",   IAD, 32'd24);

        // Back-pressure: fill the queue and stall.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b0, 32'hA0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("bp1_iad",  IAD, 32'd4);
        checkOutput("bp1_ireq", {31'd0, IREQ}, 32'd1);
        checkOutput("bp1_pc",   id_pc, 32'd0);
        IDT = 32'hA1;
        tick();
        checkOutput("bp2_iad",  IAD, 32'd8);
        checkOutput("bp2_ireq", {31'd0, IREQ}, 32'd0);
        IDT = 32'hA2;
        tick();
        checkOutput("bp3_iad",  IAD, 32'd8);
        checkOutput("bp3_ireq", {31'd0, IREQ}, 32'd0);
        checkOutput("bp3_inst", id_inst, 32'hA0);
        checkOutput("bp3_pc",   id_pc, 32'd0);
        id_ready = 1'b1;
        tick();
        checkOutput("pop_ireq", {31'd0, IREQ}, 32'd1);
        checkOutput("pop_pc",   id_pc, 32'd4);
        checkOutput("pop_inst", id_inst, 32'hA1);
        id_ready = 1'b0;
        tick();
        checkOutput("refill_iad",  IAD, 32'd12);
        checkOutput("refill_ireq", {31'd0, IREQ}, 32'd0);

        // Redirect with two entries queued and an acknowledge in the same cycle.
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h100);
        tick();
        checkOutput("redir_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("redir_iad",   IAD, 32'h100);
        checkOutput("redir_ireq",  {31'd0, IREQ}, 32'd1);
        applyStimulus(1'b0, 32'h1234, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("redir_inst", id_inst, 32'h1234);
        checkOutput("redir_pc",   id_pc, 32'h100);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h200);
        tick();
        checkOutput("redir2_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("redir2_iad",   IAD, 32'h200);
        applyStimulus(1'b0, 32'h5678, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("redir2_inst", id_inst, 32'h5678);
        checkOutput("redir2_pc",   id_pc, 32'h200);

        // Address wrap at the top of the space.
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_iad0", IAD, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'd1, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("wrap_pc0",  id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc40", id_pc4, 32'h0000_0000);
        checkOutput("wrap_iad1", IAD, 32'h0000_0000);
        IDT = 32'd2;
        tick();
        applyStimulus(1'b1, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("wrap_pc1",  id_pc, 32'h0000_0000);
        checkOutput("wrap_pc41", id_pc4, 32'h0000_0004);
        checkOutput("wrap_inst", id_inst, 32'd2);

        // Misaligned redirect.
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b1, 32'h102);
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_flag",  {31'd0, misalign}, 32'd1);
        checkOutput("mis_ireq",  {31'd0, IREQ}, 32'd0);
        checkOutput("mis_valid", {31'd0, id_valid}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("mis_pulse", {31'd0, misalign}, 32'd0);
        checkOutput("halt_ireq", {31'd0, IREQ}, 32'd0);
        tick();
        checkOutput("halt_ireq2",  {31'd0, IREQ}, 32'd0);
        checkOutput("halt_valid",  {31'd0, id_valid}, 32'd0);
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b1, 32'h200);
        tick();
        checkOutput("unhalt_ireq", {31'd0, IREQ}, 32'd1);
        checkOutput("unhalt_iad",  IAD, 32'h200);
`else
        checkOutput("mis_iad",   IAD, 32'h100);
        checkOutput("mis_ireq",  {31'd0, IREQ}, 32'd1);
        checkOutput("mis_valid", {31'd0, id_valid}, 32'd0);
`endif

        // Reset arriving in the middle of a handshake.
        applyStimulus(1'b0, 32'hCAFE, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("pre_rst_valid", {31'd0, id_valid}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("mid_rst_iad",   IAD, 32'd0);
        checkOutput("mid_rst_ireq",  {31'd0, IREQ}, 32'd0);
        checkOutput("mid_rst_inst",  id_inst, 32'd0);
        rst = 1'b0;
        ACKI_n = 1'b1;
        tick();
        checkOutput("post_rst_ireq", {31'd0, IREQ}, 32'd1);
        checkOutput("post_rst_iad",  IAD, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
